seven_seg_scan_ctrl: RTL and testbench
======================================

// Module: seven_seg_scan_ctrl
// PURPOSE
//  Time-multiplexed scan controller for an N-digit common-anode 7-segment display sharing one segment bus.
//  Cycles through the digits and feeds each BCD nibble to one registered BCD->7seg decoder.
//  Inserts a dead-time blank between digits to prevent ghosting.
//  Holds loaded values in a shadow register and applies new values only at frame boundaries.
// PARAMETERS
//  N_DIGITS      4      number of digits; digit N_DIGITS-1 is most significant; range 2..8
//  DWELL_CYCLES  50000  clock cycles each digit is lit (SHOW); >=2
//  DEAD_CYCLES   16     all-off cycles before each digit (BLANK); >=2, covers decoder latency
// PORTS
//  clock      in   1           system clock; everything is on posedge
//  reset      in   1           synchronous, active-high reset
//  load       in   1           one-cycle strobe that captures bcd_in
//  bcd_in     in   4*N_DIGITS  nibble k = digit k, LSB-first
//  out_7seg   out  7           segments {g,f,e,d,c,b,a}, active-low, registered
//  digit_en   out  N_DIGITS    anode enables, active-low, registered
//  frame_done out  1           one-cycle pulse in the last SHOW cycle of digit N_DIGITS-1
// BEHAVIOUR
//  Reset values: out_7seg=7'b111_1111, digit_en=all 1s, frame_done=0, display reg=all 4'hF,
//   pending reg cleared, state=BLANK, idx=0, cnt=0.
//  FSM per digit idx:
//   BLANK: runs DEAD_CYCLES cycles. digit_en=all 1s, out_7seg=7'h7F. The decoder input is set to nibble idx.
//   SHOW: runs DWELL_CYCLES cycles. digit_en[idx]=0 and all other enables are 1. out_7seg = decoder output.
//   Last SHOW cycle: idx wraps N_DIGITS-1 -> 0, otherwise idx+1; then go to BLANK.
//  One scan period is N_DIGITS*(DEAD_CYCLES+DWELL_CYCLES) cycles.
//  First BLANK cycle of digit 0 is the cycle after reset is released.
//  Decoder mapping: 0-9 use the standard active-low codes (0=7'b100_0000, 8=7'b000_0000).
//   Codes 10-15 give 7'b111_1111 (blank).
//  Load handling:
//   load=1 copies bcd_in into the pending reg and sets pend_v.
//   The display reg updates only on the frame_done cycle.
//   If pend_v is set then, pending -> display and pend_v is cleared.
//   If load is asserted in the frame_done cycle itself, bcd_in bypasses straight into the display reg.
//   Several loads within one frame: the last one wins.
//   The displayed value never changes in the middle of a frame.
//  Counter: a single down-counter sized for max(DEAD,DWELL); it reloads on each state change.
//  A reset in the middle of a scan aborts it at once: the pending load is lost and the display goes blank.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined:
//   Digits k>0 whose nibble is 0 and all of whose higher nibbles are 0 (or blank codes) are forced to 7'h7F in SHOW.
//   digit_en still follows the normal scan. Digit 0 is never suppressed.
//  LEADING_ZERO_BLANK_EN undefined: every 0 is shown as "0".
// STRUCTURE
//  Shared pkg seven_seg_pkg: SEG_BLANK=7'h7F, the active-low digit constant table, and the state enum {ST_BLANK, ST_SHOW}.
//  Sub-module bcd_seg_decode: registered 4-bit->7-seg decoder with 1-cycle latency, fed by the scan mux.
//  Top level holds the FSM, counter, idx, shadow/display regs, and leading-zero mask logic.
// TESTING (bench params N_DIGITS=4, DWELL=4, DEAD=2, so frame=24 cycles)
//  1. Reset: assert reset for 3 cycles -> out_7seg=7F, digit_en=4'hF, frame_done=0. After release, cycles 0-1 are all-off and cycles 2-5 show digit_en=4'b1110.
//  2. load bcd_in=16'h1234 -> after the next frame_done: digit0 shows 7'b001_1001 (4) and digit3 shows 7'b111_1001 (1). frame_done recurs every 24 cycles.
//  3. Load 16'h5678 and then 16'h9012 in the same frame -> the next frame shows 9012 only. A load on the frame_done cycle is shown in the very next frame.
//  4. Nibble 4'hB -> that digit's SHOW gives 7F. No cycle ever has two digit_en bits low. BLANK always gives 7F.
//  5. Reset asserted during the SHOW of digit 2 -> the next cycle gives reset values and the pending value is discarded.
//  6. LEADING_ZERO_BLANK_EN, load 16'h0040 -> digits 3 and 2 show 7F, digit1 shows 4, digit0 shows 0. Load 16'h0000 -> only digit0 lit. Without the macro all four digits show 0.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared constants for the 7-segment scan controller: blank code, active-low
// digit table ({g,f,e,d,c,b,a}) and the scan state enum.
package seven_seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Entry d is the active-low segment pattern for decimal digit d.
  localparam logic [9:0][6:0] DIGIT_SEG = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    if (bcd <= 4'd9) return DIGIT_SEG[bcd];
    return SEG_BLANK;
  endfunction

endpackage

// File: rtl/bcd_seg_decode.sv
// Registered BCD to 7-segment decoder, one cycle of latency.
// Codes 10-15 decode to all segments off.
module bcd_seg_decode
  import seven_seg_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_ff @(posedge clock) begin
    if (reset) seg <= SEG_BLANK;
    else       seg <= bcd_to_seg(bcd);
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed N-digit common-anode 7-segment scan controller with dead-time
// blanking and frame-synchronous display updates. Macro: LEADING_ZERO_BLANK_EN.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int DWELL_CYCLES = 50000,
  parameter int DEAD_CYCLES  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] bcd_in,
  output logic [6:0]            out_7seg,
  output logic [N_DIGITS-1:0]   digit_en,
  output logic                  frame_done,
  output state_t                state_dbg
);

  localparam int MAX_LEN = (DWELL_CYCLES > DEAD_CYCLES) ? DWELL_CYCLES : DEAD_CYCLES;
  localparam int CNT_W   = $clog2(MAX_LEN);
  localparam int IDX_W   = $clog2(N_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);

  // The counter reloads to 0 and counts down through wrap-around; a phase of
  // length L ends on the cycle where it reads -(L-1).
  localparam logic [CNT_W-1:0] DEAD_END  = -(CNT_W'(DEAD_CYCLES - 1));
  localparam logic [CNT_W-1:0] DWELL_END = -(CNT_W'(DWELL_CYCLES - 1));

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic               phase_last;

  logic [4*N_DIGITS-1:0] disp, pend;
  logic                  pend_v;
  logic [3:0]            nib [N_DIGITS];
  logic [3:0]            cur_nib;
  logic [6:0]            dec_seg;
  logic [N_DIGITS-1:0]   lz_mask;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_BLANK;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt - 1'b1;
    idx_nxt    = idx;
    phase_last = (state == ST_BLANK) ? (cnt == DEAD_END) : (cnt == DWELL_END);
    if (phase_last) begin
      cnt_nxt = '0;
      if (state == ST_BLANK) begin
        state_nxt = ST_SHOW;
      end else begin
        state_nxt = ST_BLANK;
        idx_nxt   = (idx == LAST_IDX) ? '0 : idx + 1'b1;
      end
    end
  end

  assign frame_done = (state == ST_SHOW) && (idx == LAST_IDX) && phase_last;
  assign state_dbg  = state;

  // Loads park in the shadow register; the display register only moves at frame end.
  always_ff @(posedge clock) begin
    if (reset) begin
      disp   <= '1;
      pend   <= '0;
      pend_v <= 1'b0;
    end else if (frame_done) begin
      if (load)        disp <= bcd_in;
      else if (pend_v) disp <= pend;
      pend_v <= 1'b0;
    end else if (load) begin
      pend   <= bcd_in;
      pend_v <= 1'b1;
    end
  end

  always_comb begin
    for (int k = 0; k < N_DIGITS; k++) nib[k] = disp[4*k +: 4];
  end

  assign cur_nib = nib[idx];

  bcd_seg_decode u_dec (
    .clock (clock),
    .reset (reset),
    .bcd   (cur_nib),
    .seg   (dec_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic lead;
  // Walk down from the MSD; a zero stays suppressed while everything above is 0 or blank.
  always_comb begin
    lz_mask = '0;
    lead    = 1'b1;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      lz_mask[k] = lead && (nib[k] == 4'h0);
      lead       = lead && ((nib[k] == 4'h0) || (nib[k] > 4'd9));
    end
  end
`else
  assign lz_mask = '0;
`endif

  // Outputs are registered from the next state so they line up with the FSM phase.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_7seg <= SEG_BLANK;
      digit_en <= '1;
    end else begin
      out_7seg <= SEG_BLANK;
      digit_en <= '1;
      if (state_nxt == ST_SHOW) begin
        digit_en[idx_nxt] <= 1'b0;
        if (!lz_mask[idx_nxt]) out_7seg <= dec_seg;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Self-checking bench for seven_seg_scan_ctrl (N=4, DWELL=4, DEAD=2, 24-cycle frame):
// frame-level reference model per cycle, vector table, and corner-case sequences.
module tb_seven_seg_scan_ctrl;

  localparam int N     = 4;
  localparam int DWELL = 4;
  localparam int DEAD  = 2;
  localparam int PER   = DWELL + DEAD;
  localparam int FRAME = N * PER;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ = 7'h7F;
`else
  localparam logic [6:0] LZ = 7'h40;
`endif

  logic                      clock = 1'b0;
  logic                      reset = 1'b1;
  logic                      load  = 1'b0;
  logic [15:0]               bcd_in = 16'h0;
  logic [6:0]                out_7seg;
  logic [3:0]                digit_en;
  logic                      frame_done;
  seven_seg_pkg::state_t     state_dbg;

  int errors = 0;
  int checks = 0;
  int t      = 0;
  logic [15:0] mdisp = 16'hFFFF;
  logic [15:0] mpend = 16'h0;
  logic        mpv   = 1'b0;
  logic [11:0] exp_q[$];

  typedef struct {
    logic [15:0] val;
    int          dig;
    logic [6:0]  seg;
  } vec_t;
  vec_t vecs [18];

  seven_seg_scan_ctrl #(
    .N_DIGITS     (N),
    .DWELL_CYCLES (DWELL),
    .DEAD_CYCLES  (DEAD)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .load       (load),
    .bcd_in     (bcd_in),
    .out_7seg   (out_7seg),
    .digit_en   (digit_en),
    .frame_done (frame_done),
    .state_dbg  (state_dbg)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] ref_seg(input logic [3:0] v);
    case (v)
      4'd0: return 7'b100_0000;
      4'd1: return 7'b111_1001;
      4'd2: return 7'b010_0100;
      4'd3: return 7'b011_0000;
      4'd4: return 7'b001_1001;
      4'd5: return 7'b001_0010;
      4'd6: return 7'b000_0010;
      4'd7: return 7'b111_1000;
      4'd8: return 7'b000_0000;
      4'd9: return 7'b001_0000;
      default: return 7'b111_1111;
    endcase
  endfunction

  function automatic logic ref_suppressed(input logic [15:0] d, input int k);
`ifdef LEADING_ZERO_BLANK_EN
    logic [3:0] n;
    if (k == 0) return 1'b0;
    if (d[4*k +: 4] != 4'h0) return 1'b0;
    for (int j = k + 1; j < N; j++) begin
      n = d[4*j +: 4];
      if (n >= 4'd1 && n <= 4'd9) return 1'b0;
    end
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Expected {out_7seg, digit_en, frame_done} for cycle tt of the scan.
  function automatic logic [11:0] ref_expect(input int tt, input logic [15:0] d);
    int         pos, dig;
    logic [3:0] en;
    logic [6:0] seg;
    logic       fd;
    pos = tt % PER;
    dig = (tt % FRAME) / PER;
    fd  = ((tt % FRAME) == FRAME - 1);
    if (pos < DEAD) return {7'h7F, 4'hF, fd};
    en       = 4'hF;
    en[dig]  = 1'b0;
    seg      = ref_suppressed(d, dig) ? 7'h7F : ref_seg(d[4*dig +: 4]);
    return {seg, en, fd};
  endfunction

  task automatic chk(input string name, input logic [11:0] got, input logic [11:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s t=%0d: got %h want %h", name, t, got, want);
    end
  endtask

  task automatic check_now();
    logic [11:0] e;
    e = exp_q.pop_front();
    checks++;
    if ({out_7seg, digit_en, frame_done} !== e) begin
      errors++;
      $display("FAIL scan t=%0d: got seg=%h en=%b fd=%b want seg=%h en=%b fd=%b",
               t, out_7seg, digit_en, frame_done, e[11:5], e[4:1], e[0]);
    end
  endtask

  task automatic tick();
    logic        ld;
    logic [15:0] v;
    ld = load;
    v  = bcd_in;
    @(posedge clock);
    if ((t % FRAME) == FRAME - 1) begin
      if (ld)       mdisp = v;
      else if (mpv) mdisp = mpend;
      mpv = 1'b0;
    end else if (ld) begin
      mpend = v;
      mpv   = 1'b1;
    end
    t++;
    exp_q.push_back(ref_expect(t, mdisp));
    #1;
    load = 1'b0;
    check_now();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    load  = 1'b0;
    repeat (n) @(posedge clock);
    #1;
    chk("reset_vals", {out_7seg, digit_en, frame_done}, {7'h7F, 4'hF, 1'b0});
    reset = 1'b0;
    mdisp = 16'hFFFF;
    mpend = 16'h0;
    mpv   = 1'b0;
    t     = 0;
    exp_q.delete();
    exp_q.push_back(ref_expect(0, mdisp));
    check_now();
  endtask

  task automatic run_to(input int ph);
    for (int i = 0; i < FRAME && (t % FRAME) != ph; i++) tick();
    if ((t % FRAME) != ph) begin
      checks++;
      errors++;
      $display("FAIL run_to: phase %0d want %0d", t % FRAME, ph);
    end
  endtask

  task automatic load_frame(input logic [15:0] val);
    load   = 1'b1;
    bcd_in = val;
    tick();
    run_to(0);
  endtask

  initial begin
    int gap;
    vecs[0]  = '{16'h1234, 0, 7'h19};
    vecs[1]  = '{16'h1234, 1, 7'h30};
    vecs[2]  = '{16'h1234, 2, 7'h24};
    vecs[3]  = '{16'h1234, 3, 7'h79};
    vecs[4]  = '{16'h5678, 3, 7'h12};
    vecs[5]  = '{16'h5678, 0, 7'h00};
    vecs[6]  = '{16'h9012, 3, 7'h10};
    vecs[7]  = '{16'h9012, 2, 7'h40};
    vecs[8]  = '{16'h12B4, 1, 7'h7F};
    vecs[9]  = '{16'h0040, 3, LZ};
    vecs[10] = '{16'h0040, 2, LZ};
    vecs[11] = '{16'h0040, 1, 7'h19};
    vecs[12] = '{16'h0040, 0, 7'h40};
    vecs[13] = '{16'h0000, 1, LZ};
    vecs[14] = '{16'h0000, 0, 7'h40};
    vecs[15] = '{16'h70F8, 2, 7'h40};
    vecs[16] = '{16'hB050, 2, LZ};
    vecs[17] = '{16'hB050, 3, 7'h7F};

    do_reset(3);
    tick();
    tick();
    chk("first_show_en", {8'h0, digit_en}, {8'h0, 4'b1110});

    // Frame period: frame_done must recur exactly one frame later.
    run_to(FRAME - 1);
    chk("frame_done_hi", {11'h0, frame_done}, 12'h001);
    gap = 0;
    for (int i = 0; i < FRAME + 4; i++) begin
      tick();
      gap++;
      if (frame_done) break;
    end
    chk("frame_gap", 12'(gap), 12'(FRAME));

    for (int i = 0; i < 18; i++) begin
      if (i == 0 || vecs[i].val != vecs[i-1].val) load_frame(vecs[i].val);
      run_to(vecs[i].dig * PER + DEAD + 1);
      chk($sformatf("vec%0d_seg", i), {5'h0, out_7seg}, {5'h0, vecs[i].seg});
      chk($sformatf("vec%0d_en", i), {8'h0, digit_en}, {8'h0, ~(4'b0001 << vecs[i].dig)});
    end

    // Two loads in one frame: last one wins, and nothing shows mid-frame.
    run_to(3);
    load = 1'b1; bcd_in = 16'h5678; tick();
    run_to(10);
    load = 1'b1; bcd_in = 16'h9012; tick();
    run_to(FRAME - 3);
    chk("no_midframe_update", {5'h0, out_7seg}, {5'h0, 7'h7F});
    run_to(0);
    run_to(DEAD + 1);
    chk("last_load_d0", {5'h0, out_7seg}, {5'h0, 7'h24});
    run_to(3 * PER + DEAD + 1);
    chk("last_load_d3", {5'h0, out_7seg}, {5'h0, 7'h10});

    // Load on the frame_done cycle bypasses into the very next frame.
    run_to(FRAME - 1);
    load = 1'b1; bcd_in = 16'h7777; tick();
    run_to(DEAD);
    chk("bypass_d0", {5'h0, out_7seg}, {5'h0, 7'h78});

    // Reset during the SHOW of digit 2 discards a pending load.
    run_to(5);
    load = 1'b1; bcd_in = 16'h4321; tick();
    run_to(2 * PER + DEAD + 1);
    chk("d2_show_en", {8'h0, digit_en}, {8'h0, 4'b1011});
    do_reset(1);
    run_to(FRAME - 1);
    tick();
    run_to(DEAD + 1);
    chk("pending_lost", {5'h0, out_7seg}, {5'h0, 7'h7F});

    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        load = 1'b1;
        for (int k = 0; k < N; k++)
          bcd_in[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
